scope_trigger_ctrl: RTL and testbench

Oscilloscope-style capture sequencer for the 640x480 waveform display. It watches the 25 MHz-domain audio sample stream, waits for a rising-edge trigger crossing a programmable level, and writes a pre/post-trigger window of samples into the back bank of a double-buffered sample RAM. On the next frame-start pulse it swaps banks and publishes the display start address, so the pixel renderer always reads a stable, trigger-aligned frame.

---
 rtl/scope_trigger_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_scope_trigger_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// scope_trigger_ctrl - trigger/capture sequencer for a double-buffered scope RAM
// Optional SCOPE_AUTO_TRIG_EN: forced trigger after AUTO_TIMEOUT ARMED samples.
// Revision: 1.0
// ============================================================================
module scope_trigger_ctrl #(
  parameter int unsigned DEPTH        = 560,
  parameter int unsigned PRETRIG      = 140,
  parameter int unsigned AUTO_TIMEOUT = 4800
) (
  input  logic        i_clk_25mhz,
  input  logic        i_rst_n,
  input  logic        i_sample_valid,
  input  logic [15:0] i_audio_data,
  input  logic [15:0] i_trig_level,
  input  logic [1:0]  i_mode,
  input  logic        i_arm,
  input  logic        i_frame_start,
  output logic        o_wr_en,
  output logic        o_wr_bank,
  output logic [9:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_disp_bank,
  output logic [9:0]  o_disp_start,
  output logic        o_trig_real,
  output logic [2:0]  o_state
);

  localparam logic [9:0] C_PRE  = 10'(PRETRIG);
  localparam logic [9:0] C_POST = 10'(DEPTH - PRETRIG);
  localparam logic [9:0] C_LAST = 10'(DEPTH - 1);
  localparam logic [9:0] C_WRAP = 10'(DEPTH - PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_FILL = 3'd1,
    S_ARMED    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         ptr_q, ptr_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [9:0]         trig_q, trig_d;
  logic signed [15:0] prev_q, prev_d;
  logic               pend_real_q, pend_real_d;
  logic               disp_bank_q, disp_bank_d;
  logic [9:0]         disp_start_q, disp_start_d;
  logic               trig_real_q, trig_real_d;
  logic               wr_en_q, wr_en_d;
  logic               wr_bank_q, wr_bank_d;
  logic [9:0]         wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;

  logic w_single, w_free, w_normal, w_accept, w_cross, w_auto;
  logic [9:0] w_ptr_inc;

  assign w_single  = (i_mode == 2'd2);
  assign w_free    = (i_mode == 2'd0);
  assign w_normal  = !w_single && !w_free;
  assign w_accept  = i_sample_valid &&
                     (state_q == S_PRE_FILL || state_q == S_ARMED || state_q == S_CAPTURE);
  assign w_ptr_inc = (ptr_q == C_LAST) ? 10'd0 : ptr_q + 10'd1;
  assign w_cross   = (prev_q < $signed(i_trig_level)) &&
                     ($signed(i_audio_data) >= $signed(i_trig_level));

`ifdef SCOPE_AUTO_TRIG_EN
  logic [15:0] auto_q, auto_d;
  assign w_auto = w_normal && (({1'b0, auto_q} + 17'd1) == 17'(AUTO_TIMEOUT));
`else
  assign w_auto = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    trig_d       = trig_q;
    prev_d       = prev_q;
    pend_real_d  = pend_real_q;
    disp_bank_d  = disp_bank_q;
    disp_start_d = disp_start_q;
    trig_real_d  = trig_real_q;
    wr_en_d      = w_accept;
    wr_addr_d    = ptr_q;
    wr_data_d    = i_audio_data;
`ifdef SCOPE_AUTO_TRIG_EN
    auto_d       = auto_q;
`endif
    if (w_accept) begin
      ptr_d  = w_ptr_inc;
      prev_d = $signed(i_audio_data);
    end
    case (state_q)
      S_IDLE: begin
        if (!w_single || i_arm) begin
          state_d = S_PRE_FILL;
          cnt_d   = 10'd0;
          prev_d  = 16'sd0;
        end
      end
      S_PRE_FILL: begin
        if (w_accept) begin
          if (cnt_q + 10'd1 == C_PRE) begin
            state_d = S_ARMED;
            cnt_d   = 10'd0;
`ifdef SCOPE_AUTO_TRIG_EN
            auto_d  = 16'd0;
`endif
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      S_ARMED: begin
        if (w_accept) begin
`ifdef SCOPE_AUTO_TRIG_EN
          auto_d = (auto_q == 16'hFFFF) ? auto_q : auto_q + 16'd1;
`endif
          if (w_free || w_cross || w_auto) begin
            trig_d      = ptr_q;
            pend_real_d = !w_free && w_cross;
            cnt_d       = 10'd1;
            state_d     = (C_POST == 10'd1) ? S_HOLD : S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (w_accept) begin
          cnt_d = cnt_q + 10'd1;
          if (cnt_q + 10'd1 == C_POST) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_frame_start) begin
          disp_bank_d  = !disp_bank_q;
          // Leftmost column sits PRETRIG samples before the trigger, modulo DEPTH.
          disp_start_d = (trig_q >= C_PRE) ? (trig_q - C_PRE) : (trig_q + C_WRAP);
          trig_real_d  = pend_real_q;
          state_d      = w_single ? S_IDLE : S_PRE_FILL;
          cnt_d        = 10'd0;
          prev_d       = 16'sd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_bank_d = !disp_bank_d;
  end

  always_ff @(posedge i_clk_25mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= 10'd0;
      cnt_q        <= 10'd0;
      trig_q       <= 10'd0;
      prev_q       <= 16'sd0;
      pend_real_q  <= 1'b0;
      disp_bank_q  <= 1'b0;
      disp_start_q <= 10'd0;
      trig_real_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= 10'd0;
      wr_data_q    <= 16'd0;
`ifdef SCOPE_AUTO_TRIG_EN
      auto_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      trig_q       <= trig_d;
      prev_q       <= prev_d;
      pend_real_q  <= pend_real_d;
      disp_bank_q  <= disp_bank_d;
      disp_start_q <= disp_start_d;
      trig_real_q  <= trig_real_d;
      wr_en_q      <= wr_en_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
`ifdef SCOPE_AUTO_TRIG_EN
      auto_q       <= auto_d;
`endif
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_bank    = wr_bank_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_disp_bank  = disp_bank_q;
  assign o_disp_start = disp_start_q;
  assign o_trig_real  = trig_real_q;
  assign o_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_scope_trigger_ctrl.sv
`default_nettype none
// Scoreboard bench for scope_trigger_ctrl: expected RAM writes and bank swaps
// are queued by the stimulus and popped by independent monitors.
module tb_scope_trigger_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] audio_data = 16'd0;
  logic [15:0] trig_level = 16'd0;
  logic [1:0]  mode = 2'd1;
  logic        arm = 1'b0;
  logic        frame_start = 1'b0;
  logic        wr_en, wr_bank, disp_bank, trig_real;
  logic [9:0]  wr_addr, disp_start;
  logic [15:0] wr_data;
  logic [2:0]  state;

  scope_trigger_ctrl dut (
    .i_clk_25mhz   (clk),
    .i_rst_n       (rst_n),
    .i_sample_valid(sample_valid),
    .i_audio_data  (audio_data),
    .i_trig_level  (trig_level),
    .i_mode        (mode),
    .i_arm         (arm),
    .i_frame_start (frame_start),
    .o_wr_en       (wr_en),
    .o_wr_bank     (wr_bank),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_disp_bank   (disp_bank),
    .o_disp_start  (disp_start),
    .o_trig_real   (trig_real),
    .o_state       (state)
  );

  always #20 clk = ~clk;

  typedef struct packed { logic bank; logic [9:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic bank; logic [9:0] start; logic treal; } swap_t;

  wr_t   wq[$];
  swap_t sq[$];
  int    checks = 0;
  int    errors = 0;
  logic [9:0] tb_ptr = 10'd0;
  logic       tb_bank = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=addr %0d expected=no write", wr_addr);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(w.addr));
        chk("wr_data", 32'(wr_data), 32'(w.data));
        chk("wr_bank", 32'(wr_bank), 32'(w.bank));
      end
    end
  end

  // Swap monitor: any change of the display triple must match a queued swap
  swap_t prev_disp = '0;
  always @(negedge clk) begin
    swap_t cur;
    cur = '{bank: disp_bank, start: disp_start, treal: trig_real};
    if (rst_n && cur != prev_disp) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_swap actual=bank %0d start %0d expected=no swap", disp_bank, disp_start);
      end else begin
        swap_t s;
        s = sq.pop_front();
        chk("disp_bank", 32'(disp_bank), 32'(s.bank));
        chk("disp_start", 32'(disp_start), 32'(s.start));
        chk("trig_real", 32'(trig_real), 32'(s.treal));
      end
    end
    prev_disp = cur;
  end

  initial begin
    #2_400_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] d, input bit wr, input bit fs, input bit a);
    @(posedge clk); #1;
    sample_valid = 1'b1; audio_data = d; frame_start = fs; arm = a;
    if (wr) begin
      wq.push_back('{bank: tb_bank, addr: tb_ptr, data: d});
      tb_ptr = (tb_ptr == 10'd559) ? 10'd0 : tb_ptr + 10'd1;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0; frame_start = 1'b0; arm = 1'b0;
  endtask

  task automatic sendn(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) send(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_fs(input logic b, input logic [9:0] st, input logic tr);
    sq.push_back('{bank: b, start: st, treal: tr});
    tb_bank = ~b;
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_disp_bank"}, 32'(disp_bank), 0);
    chk({tag, "_disp_start"}, 32'(disp_start), 0);
    chk({tag, "_trig_real"}, 32'(trig_real), 0);
    chk({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(posedge clk); #10 rst_n = 1'b1;
    @(posedge clk); #1 chk("release_state", 32'(state), 1);

    // Normal trigger on ramp, level 0: T=300, start=160, capture wraps 559->0
    for (int v = -300; v < -160; v++) send(16'(v), 1'b1, 1'b0, 1'b0);
    chk("prefill_done_state", 32'(state), 2);
    for (int v = -160; v < 0; v++) send(16'(v), 1'b1, 1'b0, 1'b0);
    chk("armed_before_cross", 32'(state), 2);
    send(16'd0, 1'b1, 1'b0, 1'b0);
    chk("trigger_state", 32'(state), 3);
    for (int v = 1; v < 419; v++) send(16'(v), 1'b1, 1'b0, 1'b0);
    chk("capture_one_left", 32'(state), 3);
    send(16'd419, 1'b1, 1'b0, 1'b0);
    chk("hold_state", 32'(state), 4);
    // Sample with frame_start in HOLD is dropped; swap follows
    sq.push_back('{bank: 1'b1, start: 10'd160, treal: 1'b1});
    tb_bank = 1'b0;
    send(16'd777, 1'b0, 1'b1, 1'b0);
    chk("after_swap_state", 32'(state), 1);

    // Wrap case: ptr 160, 450 samples of -5 then trigger at address 50 -> start 470
    sendn(450, 16'hFFFB);
    chk("wrap_armed", 32'(state), 2);
    send(16'd10, 1'b1, 1'b0, 1'b0);
    chk("wrap_trig_addr_model", 32'(tb_ptr), 51);
    sendn(418, 16'd20);
    // Last capture write collides with frame_start: no swap yet
    send(16'd20, 1'b1, 1'b1, 1'b0);
    chk("collision_hold", 32'(state), 4);
    repeat (3) @(posedge clk);
    #1 chk("collision_still_hold", 32'(state), 4);
    mode = 2'd2;
    pulse_fs(1'b0, 10'd470, 1'b1);
    chk("single_to_idle", 32'(state), 0);

    // Single mode: stays idle until arm; arm during CAPTURE ignored
    send(16'd5, 1'b0, 1'b0, 1'b0);
    send(16'd6, 1'b0, 1'b0, 1'b0);
    chk("single_idle_wait", 32'(state), 0);
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    chk("single_armed_prefill", 32'(state), 1);
    sendn(150, 16'hFFFF);
    send(16'd1, 1'b1, 1'b0, 1'b0);
    chk("single_capture", 32'(state), 3);
    sendn(4, 16'd7);
    send(16'd7, 1'b1, 1'b0, 1'b1);
    chk("arm_in_capture_ignored", 32'(state), 3);
    sendn(414, 16'd7);
    chk("single_hold", 32'(state), 4);
    pulse_fs(1'b1, 10'd480, 1'b1);
    chk("single_back_idle", 32'(state), 0);
    repeat (4) @(posedge clk);
    #1 chk("single_stays_idle", 32'(state), 0);

    // Free-run: triggers on first ARMED sample, trig_real 0
    mode = 2'd0;
    @(posedge clk); #1 chk("freerun_prefill", 32'(state), 1);
    sendn(140, 16'd500);
    chk("freerun_armed", 32'(state), 2);
    send(16'd500, 1'b1, 1'b0, 1'b0);
    chk("freerun_capture", 32'(state), 3);
    sendn(419, 16'd500);
    chk("freerun_hold", 32'(state), 4);
    mode = 2'd1;
    pulse_fs(1'b0, 10'd480, 1'b0);
    chk("freerun_next_prefill", 32'(state), 1);

    // Constant 100 below level 1000
    trig_level = 16'd1000;
    sendn(140, 16'd100);
    chk("auto_armed", 32'(state), 2);
`ifdef SCOPE_AUTO_TRIG_EN
    sendn(4799, 16'd100);
    chk("auto_not_yet", 32'(state), 2);
    send(16'd100, 1'b1, 1'b0, 1'b0);
    chk("auto_forced", 32'(state), 3);
    sendn(419, 16'd100);
    chk("auto_hold", 32'(state), 4);
    pulse_fs(1'b1, 10'd239, 1'b0);
    sendn(140, 16'd100);
    chk("auto_rearmed", 32'(state), 2);
`else
    sendn(300, 16'd100);
    chk("no_auto_stays_armed", 32'(state), 2);
`endif

    // Reset in the middle of a capture
    send(16'd2000, 1'b1, 1'b0, 1'b0);
    chk("mid_capture", 32'(state), 3);
    sendn(5, 16'd2000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #10 rst_n = 1'b1;
    @(posedge clk); #1 chk("midrst_release_state", 32'(state), 1);
    tb_ptr = 10'd0; tb_bank = 1'b1;
    sendn(2, 16'd42);

    repeat (4) @(posedge clk);
    #1;
    chk("write_queue_drained", 32'(wq.size()), 0);
    chk("swap_queue_drained", 32'(sq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
